// File: rtl/spi_ctrl_pkg.sv
// spi_ctrl_pkg: shared types and widths for the SPI transaction sequencer
package spi_ctrl_pkg;
  localparam int CS_SEL_W = 3;
  localparam int LEN_W = 8;
  localparam int DLY_W = 8;
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LEAD,
    ST_LOAD,
    ST_XFER,
    ST_LAG,
    ST_GAP
  } spi_ctrl_state_t;
endpackage

// File: rtl/spi_xfer_ctrl.sv
// spi_xfer_ctrl: frames a multi-byte SPI transaction around the byte engine
module spi_xfer_ctrl
  import spi_ctrl_pkg::*;
#(
  parameter int NUM_CS = 4
) (
  input  logic                clk,
  input  logic                rstz,
  input  logic                start,
  input  logic [LEN_W-1:0]    xfer_len,
  input  logic [CS_SEL_W-1:0] cs_sel,
  input  logic                rx_en,
  input  logic [DLY_W-1:0]    cs_lead,
  input  logic [DLY_W-1:0]    cs_lag,
  input  logic [DLY_W-1:0]    cs_idle,
  input  logic                abort,
  output logic                busy,
  output logic                done,
  output logic [NUM_CS-1:0]   csn,
  input  logic [7:0]          tx_data,
  input  logic                tx_vld,
  output logic                tx_rdy,
  output logic [7:0]          rx_data,
  output logic                rx_vld,
  input  logic                rx_rdy,
  output logic [7:0]          m_din,
  output logic                m_din_vld,
  input  logic                m_din_rdy,
  input  logic [7:0]          m_dout,
  input  logic                m_dout_vld
);
  spi_ctrl_state_t  r_state;
  logic [LEN_W-1:0] r_cnt;
  logic [DLY_W-1:0] r_dly;
  logic [DLY_W-1:0] r_lag;
  logic [DLY_W-1:0] r_idle;
  logic             r_rx_en;
  logic             r_abort;
  logic             r_done;
  logic             r_rx_vld;
  logic [7:0]       r_rx_data;
  logic [NUM_CS-1:0] r_csn;
  logic [NUM_CS-1:0] w_csn_sel;
  logic             w_abort;
  logic             w_din_vld;
  logic             w_launch;

  assign w_abort   = abort | r_abort;
  assign w_din_vld = (r_state == ST_LOAD) && tx_vld && !r_rx_vld;
  assign w_launch  = w_din_vld && m_din_rdy;
  assign m_din     = tx_data;
  assign m_din_vld = w_din_vld;
  assign tx_rdy    = w_launch;
  assign busy      = (r_state != ST_IDLE);
  assign done      = r_done;
  assign csn       = r_csn;
  assign rx_data   = r_rx_data;
  assign rx_vld    = r_rx_vld;

  // decode the selected line; an out-of-range index leaves every line high
  always_comb begin
    w_csn_sel = '1;
    for (int i = 0; i < NUM_CS; i++) w_csn_sel[i] = (cs_sel != CS_SEL_W'(i));
  end

  // transaction sequencer: framing delays, byte streaming, RX capture, abort
  always_ff @(posedge clk or negedge rstz) begin
    if (!rstz) begin
      r_state   <= ST_IDLE;
      r_cnt     <= '0;
      r_dly     <= '0;
      r_lag     <= '0;
      r_idle    <= '0;
      r_rx_en   <= 1'b0;
      r_abort   <= 1'b0;
      r_done    <= 1'b0;
      r_rx_vld  <= 1'b0;
      r_rx_data <= '0;
      r_csn     <= '1;
    end else begin
      r_done <= 1'b0;
      if (r_rx_vld && rx_rdy) r_rx_vld <= 1'b0;
      if (abort && (r_state inside {ST_LEAD, ST_LOAD, ST_XFER})) r_abort <= 1'b1;
      case (r_state)
        ST_IDLE: begin
          r_abort <= 1'b0;
          if (start) begin
            r_cnt   <= xfer_len;
            r_rx_en <= rx_en;
            r_dly   <= cs_lead;
            r_lag   <= cs_lag;
            r_idle  <= cs_idle;
            r_csn   <= w_csn_sel;
            r_state <= ST_LEAD;
          end
        end
        ST_LEAD: begin
          if (w_abort) begin
            r_dly   <= r_lag;
            r_state <= ST_LAG;
          end else if (r_dly == '0) r_state <= ST_LOAD;
          else r_dly <= r_dly - 1'b1;
        end
        ST_LOAD: begin
          if (w_launch) r_state <= ST_XFER;
          else if (w_abort) begin
            r_dly   <= r_lag;
            r_state <= ST_LAG;
          end
        end
        ST_XFER: begin
          if (m_dout_vld) begin
            if (r_rx_en) begin
              r_rx_data <= m_dout;
              r_rx_vld  <= 1'b1;
            end
            if (r_cnt == '0 || w_abort) begin
              r_dly   <= r_lag;
              r_state <= ST_LAG;
            end else begin
              r_cnt   <= r_cnt - 1'b1;
              r_state <= ST_LOAD;
            end
          end
        end
        ST_LAG: begin
          if (r_dly == '0) begin
            r_csn   <= '1;
            r_done  <= 1'b1;
            r_dly   <= r_idle - 1'b1;
            r_state <= (r_idle == '0) ? ST_IDLE : ST_GAP;
          end else r_dly <= r_dly - 1'b1;
        end
        ST_GAP: begin
          if (r_dly == '0) r_state <= ST_IDLE;
          else r_dly <= r_dly - 1'b1;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_spi_xfer_ctrl.sv
// tb_spi_xfer_ctrl: directed checks of the SPI transaction sequencer with an echoing byte-engine model
module tb_spi_xfer_ctrl;
  logic       clk = 1'b0;
  logic       rstz = 1'b0;
  logic       start = 1'b0;
  logic [7:0] xfer_len = '0;
  logic [2:0] cs_sel = '0;
  logic       rx_en = 1'b1;
  logic [7:0] cs_lead = '0;
  logic [7:0] cs_lag = '0;
  logic [7:0] cs_idle = '0;
  logic       abort = 1'b0;
  logic       busy, done, tx_vld, tx_rdy, rx_vld, m_din_vld, m_din_rdy, m_dout_vld;
  logic       rx_rdy = 1'b1;
  logic [3:0] csn;
  logic [7:0] tx_data, rx_data, m_din, m_dout;
  int checks = 0;
  int errors = 0;
  logic [7:0] tx_mem [256];
  int tx_pops = 0;
  int tx_n = 0;
  logic [7:0] rx_mem [256];
  int rx_n = 0;
  int done_cnt = 0;
  logic       m_busy;
  int         m_cnt;
  logic [7:0] m_byte;

  always #5 clk = ~clk;

  spi_xfer_ctrl #(.NUM_CS(4)) dut (
    .clk(clk), .rstz(rstz), .start(start), .xfer_len(xfer_len), .cs_sel(cs_sel),
    .rx_en(rx_en), .cs_lead(cs_lead), .cs_lag(cs_lag), .cs_idle(cs_idle), .abort(abort),
    .busy(busy), .done(done), .csn(csn), .tx_data(tx_data), .tx_vld(tx_vld),
    .tx_rdy(tx_rdy), .rx_data(rx_data), .rx_vld(rx_vld), .rx_rdy(rx_rdy),
    .m_din(m_din), .m_din_vld(m_din_vld), .m_din_rdy(m_din_rdy),
    .m_dout(m_dout), .m_dout_vld(m_dout_vld)
  );

  // host TX source and RX sink
  assign tx_vld  = (tx_pops < tx_n);
  assign tx_data = tx_mem[8'(tx_pops)];

  always @(posedge clk) begin
    if (tx_rdy) tx_pops <= tx_pops + 1;
    if (rx_vld && rx_rdy) begin
      rx_mem[8'(rx_n)] <= rx_data;
      rx_n <= rx_n + 1;
    end
    if (done) done_cnt <= done_cnt + 1;
  end

  // byte engine model: accepts when idle, echoes the byte 4 cycles later
  assign m_din_rdy = m_din_vld && !m_busy;

  always @(posedge clk or negedge rstz) begin
    if (!rstz) begin
      m_busy <= 1'b0; m_cnt <= 0; m_byte <= '0; m_dout <= '0; m_dout_vld <= 1'b0;
    end else begin
      m_dout_vld <= 1'b0;
      if (m_din_rdy) begin
        m_busy <= 1'b1; m_byte <= m_din; m_cnt <= 3;
      end else if (m_busy) begin
        if (m_cnt == 0) begin
          m_busy <= 1'b0; m_dout <= m_byte; m_dout_vld <= 1'b1;
        end else m_cnt <= m_cnt - 1;
      end
    end
  end

  task automatic push_tx(input logic [7:0] b);
    tx_mem[8'(tx_n)] = b;
    tx_n++;
  endtask

  task automatic start_cmd(input logic [7:0] len, input logic [2:0] sel, input logic [7:0] lead,
                           input logic [7:0] lag, input logic [7:0] idle);
    xfer_len = len; cs_sel = sel; rx_en = 1'b1; cs_lead = lead; cs_lag = lag; cs_idle = idle;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic test_reset;
    checks++; if (csn !== 4'hF) begin errors++; $display("FAIL rst_csn: got %b expected 1111", csn); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b expected 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL rst_done: got %b expected 0", done); end
    checks++; if (rx_vld !== 1'b0) begin errors++; $display("FAIL rst_rx_vld: got %b expected 0", rx_vld); end
    checks++; if (tx_rdy !== 1'b0) begin errors++; $display("FAIL rst_tx_rdy: got %b expected 0", tx_rdy); end
    checks++; if (m_din_vld !== 1'b0) begin errors++; $display("FAIL rst_m_din_vld: got %b expected 0", m_din_vld); end
    checks++; if (rx_data !== 8'h00) begin errors++; $display("FAIL rst_rx_data: got %h expected 00", rx_data); end
  endtask

  task automatic test_basic_frame;
    int p0 = tx_pops;
    int r0 = rx_n;
    int d0 = done_cnt;
    int n = 0;
    int bad = 0;
    logic [7:0] exp_rx [3] = '{8'hA5, 8'h3C, 8'hFF};
    push_tx(8'hA5); push_tx(8'h3C); push_tx(8'hFF);
    start_cmd(8'd2, 3'd1, 8'd3, 8'd2, 8'd4);
    checks++; if (csn !== 4'b1101) begin errors++; $display("FAIL basic_csn_lead: got %b expected 1101", csn); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL basic_busy: got %b expected 1", busy); end
    while (done !== 1'b1 && n < 300) begin
      if (csn !== 4'b1101) bad++;
      @(negedge clk); n++;
    end
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL basic_done_timeout: got %b expected 1", done); end
    checks++; if (bad != 0) begin errors++; $display("FAIL basic_csn_frame: got %0d bad cycles expected 0", bad); end
    checks++; if (csn !== 4'hF) begin errors++; $display("FAIL basic_csn_done: got %b expected 1111", csn); end
    @(negedge clk);
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL basic_done_pulse: got %b expected 0", done); end
    n = 1;
    while (busy === 1'b1 && n < 20) begin @(negedge clk); n++; end
    checks++; if (n != 4) begin errors++; $display("FAIL basic_gap_len: got %0d expected 4", n); end
    checks++; if (tx_pops - p0 != 3) begin errors++; $display("FAIL basic_tx_rdy: got %0d expected 3", tx_pops - p0); end
    checks++; if (done_cnt - d0 != 1) begin errors++; $display("FAIL basic_done_cnt: got %0d expected 1", done_cnt - d0); end
    checks++; if (rx_n - r0 != 3) begin errors++; $display("FAIL basic_rx_cnt: got %0d expected 3", rx_n - r0); end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (rx_mem[8'(r0 + i)] !== exp_rx[i]) begin
        errors++; $display("FAIL basic_rx_byte%0d: got %h expected %h", i, rx_mem[8'(r0 + i)], exp_rx[i]);
      end
    end
  endtask

  task automatic test_min_frame;
    int r0 = rx_n;
    int n = 0;
    logic [3:0] lc = 4'hF;
    push_tx(8'h5A);
    start_cmd(8'd0, 3'd0, 8'd0, 8'd0, 8'd0);
    checks++; if (csn !== 4'b1110) begin errors++; $display("FAIL min_csn_lead: got %b expected 1110", csn); end
    while (done !== 1'b1 && n < 100) begin
      lc = csn;
      @(negedge clk); n++;
    end
    checks++; if (n != 8) begin errors++; $display("FAIL min_frame_len: got %0d expected 8", n); end
    checks++; if (lc !== 4'b1110) begin errors++; $display("FAIL min_csn_lag: got %b expected 1110", lc); end
    checks++; if (csn !== 4'hF) begin errors++; $display("FAIL min_csn_done: got %b expected 1111", csn); end
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL min_idle: got %b expected 0", busy); end
    checks++; if (rx_mem[8'(r0)] !== 8'h5A) begin errors++; $display("FAIL min_rx: got %h expected 5a", rx_mem[8'(r0)]); end
  endtask

  task automatic test_tx_underflow;
    int p0 = tx_pops;
    int r0 = rx_n;
    int n = 0;
    int bad = 0;
    logic [7:0] exp_rx [3] = '{8'h11, 8'h22, 8'h33};
    push_tx(8'h11);
    start_cmd(8'd2, 3'd2, 8'd1, 8'd1, 8'd1);
    while (tx_pops - p0 < 1 && n < 100) begin @(negedge clk); n++; end
    repeat (20) begin
      if (csn !== 4'b1011 || m_din_vld !== 1'b0 || busy !== 1'b1) bad++;
      @(negedge clk);
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL uf_stall: got %0d bad cycles expected 0", bad); end
    checks++; if (tx_pops - p0 != 1) begin errors++; $display("FAIL uf_pops_stall: got %0d expected 1", tx_pops - p0); end
    push_tx(8'h22); push_tx(8'h33);
    n = 0;
    while (done !== 1'b1 && n < 300) begin @(negedge clk); n++; end
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL uf_done_timeout: got %b expected 1", done); end
    checks++; if (tx_pops - p0 != 3) begin errors++; $display("FAIL uf_pops: got %0d expected 3", tx_pops - p0); end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (rx_mem[8'(r0 + i)] !== exp_rx[i]) begin
        errors++; $display("FAIL uf_rx_byte%0d: got %h expected %h", i, rx_mem[8'(r0 + i)], exp_rx[i]);
      end
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_rx_backpressure;
    int p0 = tx_pops;
    int r0 = rx_n;
    int n = 0;
    int bad = 0;
    logic [7:0] exp_rx [3] = '{8'h44, 8'h55, 8'h66};
    rx_rdy = 1'b0;
    push_tx(8'h44); push_tx(8'h55); push_tx(8'h66);
    start_cmd(8'd2, 3'd3, 8'd0, 8'd0, 8'd0);
    checks++; if (csn !== 4'b0111) begin errors++; $display("FAIL bp_csn: got %b expected 0111", csn); end
    while (rx_vld !== 1'b1 && n < 100) begin @(negedge clk); n++; end
    checks++; if (rx_data !== 8'h44) begin errors++; $display("FAIL bp_rx0: got %h expected 44", rx_data); end
    repeat (10) begin
      if (m_din_vld !== 1'b0 || tx_pops - p0 != 1 || rx_data !== 8'h44 || rx_vld !== 1'b1) bad++;
      @(negedge clk);
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL bp_hold: got %0d bad cycles expected 0", bad); end
    rx_rdy = 1'b1;
    n = 0;
    while (done !== 1'b1 && n < 300) begin @(negedge clk); n++; end
    checks++; if (tx_pops - p0 != 3) begin errors++; $display("FAIL bp_pops: got %0d expected 3", tx_pops - p0); end
    checks++; if (rx_n - r0 != 3) begin errors++; $display("FAIL bp_rx_cnt: got %0d expected 3", rx_n - r0); end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (rx_mem[8'(r0 + i)] !== exp_rx[i]) begin
        errors++; $display("FAIL bp_rx_byte%0d: got %h expected %h", i, rx_mem[8'(r0 + i)], exp_rx[i]);
      end
    end
    @(negedge clk);
  endtask

  task automatic test_abort;
    int p0 = tx_pops;
    int r0 = rx_n;
    int d0 = done_cnt;
    int n = 0;
    for (int i = 0; i < 6; i++) push_tx(8'h80 + 8'(i));
    start_cmd(8'd5, 3'd1, 8'd1, 8'd1, 8'd0);
    while (tx_pops - p0 < 2 && n < 200) begin @(negedge clk); n++; end
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    n = 0;
    while (done !== 1'b1 && n < 200) begin @(negedge clk); n++; end
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL ab_done_timeout: got %b expected 1", done); end
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ab_idle: got %b expected 0", busy); end
    checks++; if (tx_pops - p0 != 2) begin errors++; $display("FAIL ab_tx_rdy: got %0d expected 2", tx_pops - p0); end
    checks++; if (rx_n - r0 != 2) begin errors++; $display("FAIL ab_rx_cnt: got %0d expected 2", rx_n - r0); end
    checks++; if (rx_mem[8'(r0 + 1)] !== 8'h81) begin errors++; $display("FAIL ab_rx1: got %h expected 81", rx_mem[8'(r0 + 1)]); end
    checks++; if (done_cnt - d0 != 1) begin errors++; $display("FAIL ab_done_cnt: got %0d expected 1", done_cnt - d0); end
    tx_n = tx_pops;
  endtask

  task automatic test_reset_midframe;
    int p0 = tx_pops;
    int r1;
    int n = 0;
    push_tx(8'h90); push_tx(8'h91); push_tx(8'h92);
    start_cmd(8'd2, 3'd0, 8'd0, 8'd0, 8'd0);
    while (tx_pops - p0 < 2 && n < 200) begin @(negedge clk); n++; end
    rstz = 1'b0;
    #1;
    checks++; if (csn !== 4'hF) begin errors++; $display("FAIL mr_csn: got %b expected 1111", csn); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mr_busy: got %b expected 0", busy); end
    checks++; if (rx_vld !== 1'b0) begin errors++; $display("FAIL mr_rx_vld: got %b expected 0", rx_vld); end
    @(negedge clk);
    rstz = 1'b1;
    tx_n = tx_pops;
    @(negedge clk);
    p0 = tx_pops;
    r1 = rx_n;
    push_tx(8'hA1);
    start_cmd(8'd0, 3'd2, 8'd0, 8'd0, 8'd0);
    checks++; if (csn !== 4'b1011) begin errors++; $display("FAIL mr_new_csn: got %b expected 1011", csn); end
    n = 0;
    while (done !== 1'b1 && n < 100) begin @(negedge clk); n++; end
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL mr_done_timeout: got %b expected 1", done); end
    checks++; if (tx_pops - p0 != 1) begin errors++; $display("FAIL mr_pops: got %0d expected 1", tx_pops - p0); end
    checks++; if (rx_mem[8'(r1)] !== 8'hA1) begin errors++; $display("FAIL mr_rx: got %h expected a1", rx_mem[8'(r1)]); end
  endtask

  initial begin
    repeat (2) @(negedge clk);
    test_reset;
    rstz = 1'b1;
    @(negedge clk);
    test_basic_frame;
    test_min_frame;
    test_tx_underflow;
    test_rx_backpressure;
    test_abort;
    test_reset_midframe;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
